// File: rtl/circuito_exp4.sv
// Sequence-memory checker: compares the player's switches against a fixed 16-entry
// one-hot ROM sequence, one entry per three clocks, ending in a hit or miss state.
module circuito_exp4 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_igual,
  output logic       db_iniciar,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_chaves,
  output logic [6:0] db_estado
);

  typedef enum logic [3:0] {
    inicial     = 4'h0,
    preparacao  = 4'h1,
    registra    = 4'h4,
    comparacao  = 4'h5,
    proximo     = 4'h6,
    fim_acertou = 4'hA,
    fim_errou   = 4'hE
  } estado_t;

  estado_t estado, estado_seguinte;

  logic       zera_c, conta_c, zera_r, registra_r;
  logic       fim_c, igual;
  logic [3:0] contagem, registro, memoria;

  // Active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexa7seg(input logic [3:0] valor);
    case (valor)
      4'h0:    hexa7seg = 7'b1000000;
      4'h1:    hexa7seg = 7'b1111001;
      4'h2:    hexa7seg = 7'b0100100;
      4'h3:    hexa7seg = 7'b0110000;
      4'h4:    hexa7seg = 7'b0011001;
      4'h5:    hexa7seg = 7'b0010010;
      4'h6:    hexa7seg = 7'b0000010;
      4'h7:    hexa7seg = 7'b1111000;
      4'h8:    hexa7seg = 7'b0000000;
      4'h9:    hexa7seg = 7'b0010000;
      4'hA:    hexa7seg = 7'b0001000;
      4'hB:    hexa7seg = 7'b0000011;
      4'hC:    hexa7seg = 7'b1000110;
      4'hD:    hexa7seg = 7'b0100001;
      4'hE:    hexa7seg = 7'b0000110;
      default: hexa7seg = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset)        contagem <= 4'h0;
    else if (zera_c)  contagem <= 4'h0;
    else if (conta_c) contagem <= contagem + 4'h1;
  end

  always_ff @(posedge clock) begin
    if (reset)           registro <= 4'h0;
    else if (zera_r)     registro <= 4'h0;
    else if (registra_r) registro <= chaves;
  end

  always_comb begin
    case (contagem)
      4'h0:    memoria = 4'h1;
      4'h1:    memoria = 4'h2;
      4'h2:    memoria = 4'h4;
      4'h3:    memoria = 4'h8;
      4'h4:    memoria = 4'h4;
      4'h5:    memoria = 4'h2;
      4'h6:    memoria = 4'h1;
      4'h7:    memoria = 4'h1;
      4'h8:    memoria = 4'h2;
      4'h9:    memoria = 4'h2;
      4'hA:    memoria = 4'h4;
      4'hB:    memoria = 4'h4;
      4'hC:    memoria = 4'h8;
      4'hD:    memoria = 4'h8;
      4'hE:    memoria = 4'h1;
      default: memoria = 4'h4;
    endcase
  end

  assign igual = (registro == memoria);
  assign fim_c = (contagem == 4'hF);

  always_ff @(posedge clock) begin
    if (reset) estado <= inicial;
    else       estado <= estado_seguinte;
  end

  // The final address ends the game before conta_c, so the counter never wraps
  always_comb begin
    estado_seguinte = estado;
    zera_c          = 1'b0;
    zera_r          = 1'b0;
    conta_c         = 1'b0;
    registra_r      = 1'b0;
    case (estado)
      inicial: begin
        if (iniciar) estado_seguinte = preparacao;
      end
      preparacao: begin
        zera_c          = 1'b1;
        zera_r          = 1'b1;
        estado_seguinte = registra;
      end
      registra: begin
        registra_r      = 1'b1;
        estado_seguinte = comparacao;
      end
      comparacao: begin
        if (!igual)     estado_seguinte = fim_errou;
        else if (fim_c) estado_seguinte = fim_acertou;
        else            estado_seguinte = proximo;
      end
      proximo: begin
        conta_c         = 1'b1;
        estado_seguinte = registra;
      end
      fim_acertou, fim_errou: begin
        if (iniciar) estado_seguinte = preparacao;
      end
      default: estado_seguinte = inicial;
    endcase
  end

  assign pronto      = (estado == fim_acertou) || (estado == fim_errou);
  assign acertou     = (estado == fim_acertou);
  assign errou       = (estado == fim_errou);
  assign db_igual    = igual;
  assign db_iniciar  = iniciar;
  assign db_contagem = hexa7seg(contagem);
  assign db_memoria  = hexa7seg(memoria);
  assign db_chaves   = hexa7seg(registro);
  assign db_estado   = hexa7seg(estado);

endmodule

// File: tb/tb_circuito_exp4.sv
// Directed bench for circuito_exp4: a cycle table for start/miss/restart, then
// hand-written loops for a full winning game and a mid-game reset.
module tb_circuito_exp4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       pronto, acertou, errou, db_igual, db_iniciar;
  logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  typedef struct {
    logic       rst;
    logic       ini;
    logic [3:0] ch;
    logic [3:0] est;
    logic [3:0] cnt;
    logic [3:0] rg;
    logic       pr;
    logic       ac;
    logic       er;
    logic       chk_ig;
    logic       ig;
  } vec_t;

  vec_t vecs [11];

  circuito_exp4 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_igual(db_igual),
    .db_iniciar(db_iniciar), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_chaves(db_chaves), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    seg = tab[v];
  endfunction

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input logic [3:0] est, input logic [3:0] cnt, input logic [3:0] rg,
                             input logic pr, input logic ac, input logic er,
                             input logic chk_ig, input logic ig);
    cmp("db_estado",   db_estado,   seg(est));
    cmp("db_contagem", db_contagem, seg(cnt));
    cmp("db_memoria",  db_memoria,  seg(rom[cnt]));
    cmp("db_chaves",   db_chaves,   seg(rg));
    cmp("pronto",      {6'b0, pronto},     {6'b0, pr});
    cmp("acertou",     {6'b0, acertou},    {6'b0, ac});
    cmp("errou",       {6'b0, errou},      {6'b0, er});
    cmp("db_iniciar",  {6'b0, db_iniciar}, {6'b0, iniciar});
    if (chk_ig) cmp("db_igual", {6'b0, db_igual}, {6'b0, ig});
  endtask

  initial begin
    //            rst  ini  ch    est   cnt   rg    pr ac er  ci ig
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0};
    vecs[1]  = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 4'h1, 4'h4, 4'h0, 4'h0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 4'h1, 4'h5, 4'h0, 4'h1, 0, 0, 0, 1, 1};
    vecs[4]  = '{1'b0, 1'b0, 4'h1, 4'h6, 4'h0, 4'h1, 0, 0, 0, 1, 1};
    vecs[5]  = '{1'b0, 1'b0, 4'h4, 4'h4, 4'h1, 4'h1, 0, 0, 0, 1, 0};
    vecs[6]  = '{1'b0, 1'b0, 4'h4, 4'h5, 4'h1, 4'h4, 0, 0, 0, 1, 0};
    vecs[7]  = '{1'b0, 1'b0, 4'h4, 4'hE, 4'h1, 4'h4, 1, 0, 1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 4'h4, 4'hE, 4'h1, 4'h4, 1, 0, 1, 0, 0};
    vecs[9]  = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 4'h4, 0, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h4, 4'h0, 4'h0, 0, 0, 0, 0, 0};

    for (int v = 0; v < 11; v++) begin
      reset   = vecs[v].rst;
      iniciar = vecs[v].ini;
      chaves  = vecs[v].ch;
      applyStimulus();
      checkOutput(vecs[v].est, vecs[v].cnt, vecs[v].rg, vecs[v].pr, vecs[v].ac,
                  vecs[v].er, vecs[v].chk_ig, vecs[v].ig);
    end

    // Full winning game starting from registra at entry 0
    for (int i = 0; i < 16; i++) begin
      chaves = rom[i];
      applyStimulus();
      checkOutput(4'h5, 4'(i), rom[i], 0, 0, 0, 1, 1);
      applyStimulus();
      if (i < 15) begin
        checkOutput(4'h6, 4'(i), rom[i], 0, 0, 0, 1, 1);
        applyStimulus();
        checkOutput(4'h4, 4'(i + 1), rom[i], 0, 0, 0, 0, 0);
      end else begin
        checkOutput(4'hA, 4'hF, rom[i], 1, 1, 0, 1, 1);
      end
    end
    applyStimulus();
    checkOutput(4'hA, 4'hF, 4'h4, 1, 1, 0, 0, 0);

    // New game from fim_acertou, then reset while in proximo at entry 5
    iniciar = 1'b1;
    applyStimulus();
    checkOutput(4'h1, 4'hF, 4'h4, 0, 0, 0, 0, 0);
    iniciar = 1'b0;
    applyStimulus();
    checkOutput(4'h4, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chaves = rom[i];
      applyStimulus();
      checkOutput(4'h5, 4'(i), rom[i], 0, 0, 0, 1, 1);
      applyStimulus();
      checkOutput(4'h6, 4'(i), rom[i], 0, 0, 0, 1, 1);
      if (i < 5) begin
        applyStimulus();
        checkOutput(4'h4, 4'(i + 1), rom[i], 0, 0, 0, 0, 0);
      end
    end
    reset = 1'b1;
    applyStimulus();
    checkOutput(4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput(4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
